// File: rtl/wb_line_memory.sv
// Wishbone slave line memory: 2^ADR_W x 128-bit lines, byte-lane writes, LATENCY-cycle response.
// Define RTY_INJECT_EN to answer every RTY_PERIOD-th accepted request with a retry instead of an ack.

module wb_line_memory #(
    parameter int ADR_W      = 12,
    parameter int LATENCY    = 4,
    parameter int RTY_PERIOD = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc,
    input  logic             wb_stb,
    input  logic             wb_we,
    input  logic [15:0]      wb_sel,
    input  logic [ADR_W-1:0] wb_adr,
    input  logic [127:0]     wb_dat_m,
    output logic [127:0]     wb_dat_s,
    output logic             wb_ack,
    output logic             wb_rty,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADR_W;
    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 255 || RTY_PERIOD < 2) begin : g_bad_params
        $error("wb_line_memory: LATENCY must be 1..255 and RTY_PERIOD >= 2");
    end

    logic [127:0]     mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rty_q, rty_d;
    logic [127:0]     rdat_q, rdat_d;

    logic             we_q, we_d;
    logic [15:0]      sel_q, sel_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [127:0]     wdat_q, wdat_d;

    logic             rd_load;
    logic [ADR_W-1:0] rd_adr;
    logic             mem_wr;
    logic             inject;

`ifdef RTY_INJECT_EN
    localparam int RC_W = $clog2(RTY_PERIOD + 1);

    logic [RC_W-1:0] req_cnt_q, req_cnt_d;

    // The request that would bring the count up to RTY_PERIOD is the one retried.
    always_comb begin
        inject = (req_cnt_q == RC_W'(RTY_PERIOD - 1));
    end
`else
    assign inject = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rty_d   = rty_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rd_load = 1'b0;
        rd_adr  = adr_q;
`ifdef RTY_INJECT_EN
        req_cnt_d = req_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    we_d   = wb_we;
                    sel_d  = wb_sel;
                    adr_d  = wb_adr;
                    wdat_d = wb_dat_m;
                    rty_d  = inject;
`ifdef RTY_INJECT_EN
                    req_cnt_d = inject ? '0 : req_cnt_q + 1'b1;
`endif
                    // A single-cycle latency skips WAIT entirely, so the read uses the live address.
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        rd_adr  = wb_adr;
                        rd_load = !wb_we && !inject;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_cyc) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rty_d   = 1'b0;
`ifdef RTY_INJECT_EN
                    req_cnt_d = '0;
`endif
                end else if (cnt_q <= 8'd1) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    rd_load = !we_q && !rty_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rty_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data is captured on the edge entering RESP and held until the next read completes.
    always_comb begin
        rdat_d = rdat_q;
        if (rd_load) begin
            rdat_d = mem_q[rd_adr];
        end
    end

    always_comb begin
        mem_wr = (state_q == S_RESP) && we_q && !rty_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 16; i++) begin
                if (sel_q[i]) begin
                    mem_q[adr_q][8*i +: 8] <= wdat_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
`ifdef RTY_INJECT_EN
            req_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rty_q   <= rty_d;
            rdat_q  <= rdat_d;
`ifdef RTY_INJECT_EN
            req_cnt_q <= req_cnt_d;
`endif
        end
    end

    // Latched request fields carry no reset; they are only consulted outside IDLE.
    always_ff @(posedge clk) begin
        we_q   <= we_d;
        sel_q  <= sel_d;
        adr_q  <= adr_d;
        wdat_q <= wdat_d;
    end

    assign wb_ack   = (state_q == S_RESP) && !rty_q;
    assign wb_rty   = (state_q == S_RESP) && rty_q;
    assign wb_dat_s = rdat_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_line_memory.sv
// Self-checking bench for wb_line_memory: vector table, corner sequences, randomized traffic vs. a line/byte model.
`timescale 1ns/1ps

module tb_wb_line_memory;

    localparam int ADR_W      = 12;
    localparam int LATENCY    = 4;
    localparam int RTY_PERIOD = 5;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D2 = 128'hCAFEF00D_0BADC0DE_13579BDF_2468ACE0;
    localparam logic [127:0] D3 = 128'h10101010_20202020_30303030_40404040;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_cyc, wb_stb, wb_we;
    logic [15:0]      wb_sel;
    logic [ADR_W-1:0] wb_adr;
    logic [127:0]     wb_dat_m, wb_dat_s;
    logic             wb_ack, wb_rty, busy;

    wb_line_memory #(
        .ADR_W(ADR_W), .LATENCY(LATENCY), .RTY_PERIOD(RTY_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
        .wb_ack(wb_ack), .wb_rty(wb_rty), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: whole-line storage, byte-merge writes, accept count for retry prediction.
    logic [127:0] model [1 << ADR_W];
    bit           known [1 << ADR_W];
    logic [127:0] last_rdat;
    int           n_acc;

    typedef struct {
        logic             we;
        logic [15:0]      sel;
        logic [ADR_W-1:0] adr;
        logic [127:0]     dat;
        logic [127:0]     exp;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_acc = 0;
        last_rdat = '0;
    endtask

    // One bus request; inputs are scrambled after acceptance to prove they are latched.
    task automatic txn(input logic we, input logic [15:0] sel, input logic [ADR_W-1:0] adr,
                       input logic [127:0] dat, output logic ack, output logic rty,
                       output int lat, output logic [127:0] rdat, output int unsigned ack_cyc);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_m = dat;
        ack = 1'b0; rty = 1'b0; lat = 0; rdat = '0; ack_cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (wb_ack || wb_rty) begin
                ack = wb_ack; rty = wb_rty; lat = i; rdat = wb_dat_s; ack_cyc = cycle_no;
                break;
            end
            if (i == 1) begin
                wb_we = ~we; wb_sel = ~sel; wb_adr = ~adr; wb_dat_m = ~dat;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic bus_op(input string name, input logic we, input logic [15:0] sel,
                          input logic [ADR_W-1:0] adr, input logic [127:0] dat,
                          output logic [127:0] rd, output int unsigned ac);
        logic ack, rty;
        int   lat;
        bit   exp_rty, done;
        done = 1'b0; rd = '0; ac = 0;
        for (int attempt = 0; attempt < 2 && !done; attempt++) begin
            n_acc++;
            exp_rty = 1'b0;
`ifdef RTY_INJECT_EN
            exp_rty = (n_acc % RTY_PERIOD) == 0;
`endif
            txn(we, sel, adr, dat, ack, rty, lat, rd, ac);
            chk({name, " latency"}, 128'(lat), 128'(LATENCY));
            chk({name, " ack/rty"}, {126'd0, ack, rty}, exp_rty ? 128'd1 : 128'd2);
            if (we || rty) chk({name, " dat_s held"}, rd, last_rdat);
            done = ack;
        end
        if (done) begin
            if (we) begin
                for (int i = 0; i < 16; i++)
                    if (sel[i]) model[adr][8*i +: 8] = dat[8*i +: 8];
                if (sel == 16'hFFFF) known[adr] = 1'b1;
            end else if (known[adr]) begin
                chk({name, " rdata"}, rd, model[adr]);
                last_rdat = model[adr];
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0]     rd, rd0, rd1;
        int unsigned      c0, c1;
        logic [ADR_W-1:0] pool [16];
        bit               seen;

        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_sel = '0; wb_adr = '0; wb_dat_m = '0;
        n_acc = 0; last_rdat = '0;

        tbl[0]  = '{1'b1, 16'hFFFF, 12'h123, D0, '0};
        tbl[1]  = '{1'b0, 16'h0000, 12'h123, '0, D0};
        tbl[2]  = '{1'b1, 16'h0001, 12'h123, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEA5, '0};
        tbl[3]  = '{1'b0, 16'hFFFF, 12'h123, '0, 128'h00112233_44556677_8899AABB_CCDDEEA5};
        tbl[4]  = '{1'b1, 16'h0000, 12'h123, ONES, '0};
        tbl[5]  = '{1'b0, 16'h0000, 12'h123, '0, 128'h00112233_44556677_8899AABB_CCDDEEA5};
        tbl[6]  = '{1'b1, 16'hFFFF, 12'h055, '0, '0};
        tbl[7]  = '{1'b1, 16'h8001, 12'h055, ONES, '0};
        tbl[8]  = '{1'b0, 16'h0000, 12'h055, '0, 128'hFF000000_00000000_00000000_000000FF};
        tbl[9]  = '{1'b1, 16'hFFFF, 12'h000, D1, '0};
        tbl[10] = '{1'b1, 16'hFFFF, 12'hFFF, D2, '0};
        tbl[11] = '{1'b1, 16'hFFFF, 12'h010, D3, '0};
        tbl[12] = '{1'b0, 16'h0000, 12'h010, '0, D3};

        reset_dut();
        chk("reset ack", {127'd0, wb_ack}, '0);
        chk("reset rty", {127'd0, wb_rty}, '0);
        chk("reset busy", {127'd0, busy}, '0);
        chk("reset dat_s", wb_dat_s, '0);

        for (int i = 0; i < 13; i++) begin
            bus_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, rd, c0);
            if (!tbl[i].we) chk($sformatf("vec%0d table rdata", i), rd, tbl[i].exp);
        end
        @(negedge clk);
        chk("ack one cycle", {127'd0, wb_ack}, '0);

        // Back-to-back reads: next request presented the cycle after ACK.
        reset_dut();
        bus_op("b2b rd000", 1'b0, 16'h0, 12'h000, '0, rd0, c0);
        bus_op("b2b rdFFF", 1'b0, 16'h0, 12'hFFF, '0, rd1, c1);
        chk("b2b ack spacing", 128'(c1 - c0), 128'd5);
        chk("b2b data000", rd0, D1);
        chk("b2b dataFFF", rd1, D2);

        // Abort: CYC dropped two cycles after acceptance.
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 16'hFFFF;
        wb_adr = 12'h010; wb_dat_m = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
        @(negedge clk);
        chk("abort busy in wait", {127'd0, busy}, 128'd1);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack || wb_rty) seen = 1'b1;
        end
        n_acc = 0;
        chk("abort no response", {127'd0, seen}, '0);
        chk("abort dat_s held", wb_dat_s, D2);
        chk("abort busy", {127'd0, busy}, '0);
        bus_op("abort readback", 1'b0, 16'h0, 12'h010, '0, rd, c0);
        chk("abort old contents", rd, D3);

        // Reset coinciding with the RESP cycle of a write.
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 16'hFFFF;
        wb_adr = 12'h010; wb_dat_m = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wb_ack || wb_rty) seen = 1'b1;
        end
        chk("rst-resp response seen", {127'd0, seen}, 128'd1);
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        chk("rst-resp ack", {127'd0, wb_ack}, '0);
        chk("rst-resp busy", {127'd0, busy}, '0);
        chk("rst-resp dat_s", wb_dat_s, '0);
        rst = 1'b0; n_acc = 0; last_rdat = '0;
        bus_op("rst-resp readback", 1'b0, 16'h0, 12'h010, '0, rd, c0);
        chk("rst-resp array unchanged", rd, D3);

`ifdef RTY_INJECT_EN
        begin
            logic ack, rty;
            int   lat;
            logic [127:0] wv;
            reset_dut();
            for (int k = 0; k < 4; k++) begin
                wv = 128'hA5A50000_00000000_00000000_00000000 | 128'(k + 1);
                txn(1'b1, 16'hFFFF, ADR_W'(12'h200 + k), wv, ack, rty, lat, rd, c0);
                chk($sformatf("rty write%0d ack", k + 1), {126'd0, ack, rty}, 128'd2);
                model[12'h200 + k] = wv; known[12'h200 + k] = 1'b1;
            end
            txn(1'b1, 16'hFFFF, 12'h203, D0, ack, rty, lat, rd, c0);
            chk("rty write5 rty", {126'd0, ack, rty}, 128'd1);
            chk("rty write5 latency", 128'(lat), 128'(LATENCY));
            txn(1'b0, 16'h0, 12'h203, '0, ack, rty, lat, rd, c0);
            chk("rty array unchanged", rd, 128'hA5A50000_00000000_00000000_00000004);
            txn(1'b1, 16'hFFFF, 12'h203, D0, ack, rty, lat, rd, c0);
            chk("rty retry ack", {126'd0, ack, rty}, 128'd2);
            txn(1'b0, 16'h0, 12'h203, '0, ack, rty, lat, rd, c0);
            chk("rty retry committed", rd, D0);
            model[12'h203] = D0;
        end
`endif

        // Randomized traffic against the reference model.
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            pool[k] = ADR_W'($urandom_range(0, (1 << ADR_W) - 1));
            bus_op($sformatf("pool init%0d", k), 1'b1, 16'hFFFF, pool[k],
                   {$urandom, $urandom, $urandom, $urandom}, rd, c0);
        end
        for (int n = 0; n < 150; n++) begin
            logic [15:0] sel;
            int          r;
            r = $urandom_range(0, 3);
            sel = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
            bus_op($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), sel,
                   pool[$urandom_range(0, 15)], {$urandom, $urandom, $urandom, $urandom}, rd, c0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
